// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract engine that drives one full-adder /
// full-subtractor cell per clock, LSB first. The carry or borrow is held in a
// flop between bits.
//
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   start_valid/start_ready request handshake; a, b, op are sampled on accept
//   op                      0 = add (a+b), 1 = subtract (a-b)
//   a, b                    unsigned WIDTH-bit operands
//   res_valid/res_ready     result handshake
//   result                  (a +/- b) mod 2^WIDTH
//   cout                    add: carry-out, sub: borrow-out (a < b)
//   busy                    high while shifting or holding a result
module serial_addsub #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             op_q;
  logic             carry;
  logic [CNT_W-1:0] count;

  // One FA/FS cell evaluated on the current LSBs and the carry/borrow flop.
  logic x, y, s, c_next;

  always_comb begin
    x      = a_sh[0];
    y      = b_sh[0];
    s      = x ^ y ^ carry;
    c_next = op_q ? ((~(x ^ y) & carry) | (~x & y))
                  : ((x & y) | (y & carry) | (carry & x));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      result      <= '0;
      cout        <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      op_q        <= 1'b0;
      carry       <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            a_sh        <= a;
            b_sh        <= b;
            op_q        <= op;
            carry       <= 1'b0;
            count       <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          // Result fills from the MSB side so after WIDTH bits bit 0 lands at [0].
          result <= {s, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= c_next;
          count  <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            cout      <= c_next;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // start_ready rises only after the handoff edge, so no request
          // can be accepted in the same cycle the result is taken.
          if (res_ready) begin
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
